// File: rtl/sodor_mem_arb_pkg.sv
// Shared types and constants for the Sodor unified-memory arbiter:
// FSM states, memory size codes and transaction-owner encoding.
package sodor_mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [2:0] MEM_BE_BYTE = 3'b001;
    localparam logic [2:0] MEM_BE_HALF = 3'b010;
    localparam logic [2:0] MEM_BE_WORD = 3'b011;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/sodor_mem_arb_starve.sv
// Saturating count of consecutive grant slots in which a pending fetch lost
// to the data port; force_fetch_o asserts once the limit is reached.
module sodor_mem_arb_starve #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             imem_req_i,
    input  logic             data_win_i,
    input  logic             fetch_win_i,
    output logic             force_fetch_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_win_i) begin
            cnt_d = '0;
        end else if (data_win_i && imem_req_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch_o = (cnt_q == LIMIT_C);
    assign cnt_o         = cnt_q;

endmodule

// File: rtl/sodor_mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported memory,
// one transaction outstanding. Define SODOR_MEM_ARB_PERF_EN for grant/conflict counters.
module sodor_mem_arbiter
    import sodor_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_gnt,
    output logic              imem_rvalid,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_req,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_we,
    input  logic [2:0]        dmem_be,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_gnt,
    output logic              dmem_rvalid,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_owner,
    output arb_state_e        dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
`ifdef SODOR_MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_igrant,
    output logic [31:0]       perf_dgrant,
    output logic [31:0]       perf_conflict
`endif
);

    // Handshake: a requester holds req and its fields until it sees gnt in the
    // same cycle; gnt is the accept strobe and nothing unaccepted is latched.
    // Each accepted request gets exactly one rvalid on its own port later.

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       slot, resp_fire, d_win, i_win, force_fetch;

    // Reset masks the slot and the response so nothing leaks out mid-reset.
    assign resp_fire = !reset && (state_q == BUSY) && mem_rvalid;
    assign slot      = !reset && ((state_q == IDLE) || mem_rvalid);
    assign d_win     = slot && dmem_req && !(imem_req && force_fetch);
    assign i_win     = slot && imem_req && !d_win;

    sodor_mem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clock         (clock),
        .reset         (reset),
        .imem_req_i    (imem_req),
        .data_win_i    (d_win),
        .fetch_win_i   (i_win),
        .force_fetch_o (force_fetch),
        .cnt_o         (dbg_starve_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_FETCH;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (d_win || i_win) begin
            state_d = BUSY;
            owner_d = d_win ? OWNER_DATA : OWNER_FETCH;
        end else if (resp_fire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        imem_gnt    = 1'b0;
        dmem_gnt    = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_be      = 3'b000;
        mem_wdata   = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        if (d_win) begin
            dmem_gnt  = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = dmem_addr;
            mem_we    = dmem_we;
            mem_be    = dmem_be;
            mem_wdata = dmem_wdata;
        end else if (i_win) begin
            imem_gnt  = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = imem_addr;
            mem_be    = MEM_BE_WORD;
        end
        if (resp_fire) begin
            if (owner_q == OWNER_DATA) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem_rdata;
            end else begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_rdata;
            end
        end
    end

    assign arb_owner = owner_q;
    assign dbg_state = state_q;

`ifdef SODOR_MEM_ARB_PERF_EN
    logic [31:0] perf_igrant_q, perf_dgrant_q, perf_conflict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_igrant_q   <= '0;
            perf_dgrant_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (i_win) perf_igrant_q <= perf_igrant_q + 32'd1;
            if (d_win) perf_dgrant_q <= perf_dgrant_q + 32'd1;
            if (slot && imem_req && dmem_req) perf_conflict_q <= perf_conflict_q + 32'd1;
        end
    end

    assign perf_igrant   = perf_igrant_q;
    assign perf_dgrant   = perf_dgrant_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Directed plus light random bench for sodor_mem_arbiter with a behavioural
// memory and an expected-response queue.
module tb_sodor_mem_arbiter;
    import sodor_mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int CW = $clog2(SL + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req, imem_gnt, imem_rvalid;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [AW-1:0] dmem_addr;
    logic [2:0]    dmem_be;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          mem_req, mem_we, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          arb_owner;
    arb_state_e    dbg_state;
    logic [CW-1:0] dbg_starve_cnt;
`ifdef SODOR_MEM_ARB_PERF_EN
    logic [31:0]   perf_igrant, perf_dgrant, perf_conflict;
    logic [31:0]   pi0, pd0, pc0;
`endif

    sodor_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .arb_owner(arb_owner), .dbg_state(dbg_state),
        .dbg_starve_cnt(dbg_starve_cnt)
`ifdef SODOR_MEM_ARB_PERF_EN
        , .perf_igrant(perf_igrant), .perf_dgrant(perf_dgrant),
        .perf_conflict(perf_conflict)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model: one response per accepted request, mem_lat cycles later.
    int            cyc = 0;
    int            mem_lat = 1;
    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clock);
            if (mem_req === 1'b1) begin
                pend_addr.push_back(mem_addr);
                pend_due.push_back(cyc + mem_lat);
            end
            @(posedge clock);
            #1;
            cyc++;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_data(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    // Scoreboard: bit DW of each entry is the expected port (1 = data).
    logic [DW:0] exp_q[$];
    logic [DW:0] e;

    always @(negedge clock) begin
        if (imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {imem_rvalid, dmem_rvalid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                if (e[DW]) begin
                    check("resp_port_data", {imem_rvalid, dmem_rvalid}, 2'b01);
                    check("dmem_rdata", dmem_rdata, e[DW-1:0]);
                    check("imem_rdata_quiet", imem_rdata, 0);
                end else begin
                    check("resp_port_fetch", {imem_rvalid, dmem_rvalid}, 2'b10);
                    check("imem_rdata", imem_rdata, e[DW-1:0]);
                    check("dmem_rdata_quiet", dmem_rdata, 0);
                end
            end
        end
    end

    int   mcnt;
    logic exp_dw;
    logic which;

    initial begin
        reset = 1'b1;
        imem_req = 0; imem_addr = '0;
        dmem_req = 0; dmem_addr = '0; dmem_we = 0; dmem_be = 3'b000; dmem_wdata = '0;
        repeat (2) tick();
        imem_req = 1; imem_addr = 32'h100;
        @(negedge clock);
        check("rst_imem_gnt", imem_gnt, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        reset = 1'b0; imem_req = 0;
        @(negedge clock);
        check("rst_state", dbg_state, IDLE);
        check("rst_starve", dbg_starve_cnt, 0);
        check("rst_owner", arb_owner, 0);
        check("rst_gnts", {imem_gnt, dmem_gnt}, 2'b00);
        check("rst_rvalids", {imem_rvalid, dmem_rvalid}, 2'b00);
        check("rst_rdata", {imem_rdata, dmem_rdata}, 0);
        check("rst_mem_wdata", mem_wdata, 0);

        // Fetch only
        tick();
        imem_req = 1; imem_addr = 32'h100;
        @(negedge clock);
        check("t1_imem_gnt", imem_gnt, 1);
        check("t1_dmem_gnt", dmem_gnt, 0);
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_we", mem_we, 0);
        check("t1_mem_be", mem_be, MEM_BE_WORD);
        check("t1_mem_wdata", mem_wdata, 0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick();
        imem_req = 0;
        @(negedge clock);
        check("t1_owner", arb_owner, OWNER_FETCH);
        check("t1_imem_rvalid", imem_rvalid, 1);
        check("t1_dmem_rvalid", dmem_rvalid, 0);
        check("t1_idle_slot_req", mem_req, 0);
        tick();
        @(negedge clock);
        check("t1_back_idle", dbg_state, IDLE);

        // Simultaneous fetch and byte store
        tick();
        imem_req = 1; imem_addr = 32'h200;
        dmem_req = 1; dmem_addr = 32'h80; dmem_we = 1; dmem_be = MEM_BE_BYTE;
        dmem_wdata = 32'h12345678;
        @(negedge clock);
        check("t2_dmem_gnt", dmem_gnt, 1);
        check("t2_imem_gnt", imem_gnt, 0);
        check("t2_mem_addr", mem_addr, 32'h80);
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_be", mem_be, MEM_BE_BYTE);
        check("t2_mem_wdata", mem_wdata, 32'h12345678);
        exp_q.push_back({1'b1, mem_data(32'h80)});
        tick();
        dmem_req = 0; dmem_we = 0; dmem_wdata = '0;
        @(negedge clock);
        check("t2_starve_1", dbg_starve_cnt, 1);
        check("t2_owner_data", arb_owner, OWNER_DATA);
        check("t2_imem_gnt2", imem_gnt, 1);
        check("t2_mem_addr2", mem_addr, 32'h200);
        check("t2_mem_we2", mem_we, 0);
        check("t2_mem_be2", mem_be, MEM_BE_WORD);
        check("t2_mem_wdata2", mem_wdata, 0);
        exp_q.push_back({1'b0, mem_data(32'h200)});
        tick();
        imem_req = 0;
        @(negedge clock);
        check("t2_starve_0", dbg_starve_cnt, 0);
        check("t2_owner_fetch", arb_owner, OWNER_FETCH);
        tick();
        tick();

        // Starvation: six slots with fetch pending
`ifdef SODOR_MEM_ARB_PERF_EN
        pi0 = perf_igrant; pd0 = perf_dgrant; pc0 = perf_conflict;
`endif
        imem_req = 1; imem_addr = 32'h300;
        dmem_req = 1; dmem_addr = 32'h40; dmem_be = MEM_BE_WORD;
        mcnt = 0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clock);
            exp_dw = !(imem_req && mcnt == SL);
            check($sformatf("t3_slot%0d_dgnt", s), dmem_gnt, exp_dw);
            check($sformatf("t3_slot%0d_ignt", s), imem_gnt, !exp_dw);
            check($sformatf("t3_slot%0d_starve", s), dbg_starve_cnt, mcnt);
            if (exp_dw) begin
                exp_q.push_back({1'b1, mem_data(dmem_addr)});
                if (imem_req && mcnt < SL) mcnt++;
            end else begin
                exp_q.push_back({1'b0, mem_data(imem_addr)});
                mcnt = 0;
            end
            tick();
            if (!exp_dw) imem_req = 0;
            else dmem_addr += 4;
        end
        dmem_req = 0;
        @(negedge clock);
`ifdef SODOR_MEM_ARB_PERF_EN
        check("t3_perf_dgrant", perf_dgrant - pd0, 5);
        check("t3_perf_igrant", perf_igrant - pi0, 1);
        check("t3_perf_conflict", perf_conflict - pc0, 5);
`endif
        check("t3_starve_end", dbg_starve_cnt, 0);
        tick();
        tick();

        // Back-to-back loads with 1-cycle memory
        dmem_req = 1; dmem_addr = 32'h0; dmem_be = MEM_BE_WORD; dmem_we = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("t4_gnt%0d", i), dmem_gnt, 1);
            check($sformatf("t4_req%0d", i), mem_req, 1);
            check($sformatf("t4_addr%0d", i), mem_addr, i * 4);
            if (i > 0) check($sformatf("t4_rvalid%0d", i), dmem_rvalid, 1);
            exp_q.push_back({1'b1, mem_data(dmem_addr)});
            tick();
            if (i < 2) dmem_addr += 4;
            else dmem_req = 0;
        end
        @(negedge clock);
        check("t4_rvalid_last", dmem_rvalid, 1);
        check("t4_req_drop", mem_req, 0);
        tick();

        // Reset while a data load is outstanding
        mem_lat = 3;
        imem_req = 1; imem_addr = 32'h400;
        dmem_req = 1; dmem_addr = 32'h20;
        @(negedge clock);
        check("t5_dmem_gnt", dmem_gnt, 1);
        tick();
        dmem_req = 0; reset = 1'b1;
        @(negedge clock);
        check("t5_starve_pre", dbg_starve_cnt, 1);
        check("t5_rst_gnt", {imem_gnt, dmem_gnt}, 2'b00);
        check("t5_rst_mem_req", mem_req, 0);
        tick();
        reset = 1'b0; imem_req = 0; mem_lat = 1;
        @(negedge clock);
        check("t5_state", dbg_state, IDLE);
        check("t5_starve", dbg_starve_cnt, 0);
        check("t5_owner", arb_owner, OWNER_FETCH);
        tick();
        @(negedge clock);
        check("t5_stray_rvalid", {imem_rvalid, dmem_rvalid}, 2'b00);
        check("t5_stray_state", dbg_state, IDLE);
        tick();

        // Random isolated requests
        for (int k = 0; k < 8; k++) begin
            mem_lat = $urandom_range(1, 2);
            which = 1'($urandom_range(0, 1));
            if (which) begin
                dmem_req = 1; dmem_addr = $urandom & 32'hFFFF_FFFC;
                dmem_we = 1'($urandom_range(0, 1)); dmem_be = 3'($urandom_range(1, 6));
                dmem_wdata = $urandom;
            end else begin
                imem_req = 1; imem_addr = $urandom & 32'hFFFF_FFFC;
            end
            @(negedge clock);
            if (which) begin
                check($sformatf("rnd%0d_dgnt", k), dmem_gnt, 1);
                check($sformatf("rnd%0d_we", k), mem_we, dmem_we);
                check($sformatf("rnd%0d_be", k), mem_be, dmem_be);
                check($sformatf("rnd%0d_wdata", k), mem_wdata, dmem_wdata);
                exp_q.push_back({1'b1, mem_data(dmem_addr)});
            end else begin
                check($sformatf("rnd%0d_ignt", k), imem_gnt, 1);
                check($sformatf("rnd%0d_fetch_be", k), mem_be, MEM_BE_WORD);
                exp_q.push_back({1'b0, mem_data(imem_addr)});
            end
            tick();
            dmem_req = 0; imem_req = 0; dmem_we = 0;
            repeat (3) tick();
        end

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clock);
        check("drain_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sodor_mem_arbiter.md
Name: sodor_mem_arbiter

Overview:
- Shares one single-ported memory between the 2-stage core's instruction-fetch port and data port.
- Only one transaction is outstanding at a time.
- Data port has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT consecutive losses.
- Sits between the core's imem/dmem interfaces and the unified memory. Its memory-side signals (mem_req, mem_addr, mem_we, mem_be, mem_wdata, mem_rdata) are the ones the RVFI monitor consumes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (>=1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  in  1  fetch request, held until granted
- imem_addr  in  ADDR_W  fetch address
- imem_gnt  out  1  fetch request accepted this cycle
- imem_rvalid  out  1  fetch response valid
- imem_rdata  out  DATA_W  fetch response data
- dmem_req  in  1  data request, held until granted
- dmem_addr  in  ADDR_W  data address
- dmem_we  in  1  1 = store
- dmem_be  in  3  size code: 001 byte, 010 half, other nonzero word, 101/110 unsigned load variants
- dmem_wdata  in  DATA_W  store data
- dmem_gnt  out  1  data request accepted this cycle
- dmem_rvalid  out  1  data response valid (loads and stores)
- dmem_rdata  out  DATA_W  load data
- mem_req  out  1  request to memory
- mem_addr  out  ADDR_W  muxed address
- mem_we  out  1  muxed write enable; 0 for fetch
- mem_be  out  3  muxed size code; 3'b011 (word) for fetch
- mem_wdata  out  DATA_W  store data; 0 for fetch
- mem_rvalid  in  1  memory response, one per accepted request, at least 1 cycle later
- mem_rdata  in  DATA_W  memory read data
- arb_owner  out  1  owner of the outstanding transaction: 1 = data, 0 = fetch

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE, starve_cnt = 0, arb_owner = 0.
  - All gnt, rvalid and mem_req outputs are 0; all rdata, addr and wdata outputs are 0.
- States: IDLE, BUSY.
- Grant slot:
  - A grant may be issued when state == IDLE, or when state == BUSY and mem_rvalid == 1 (back-to-back issue).
  - No grant is issued in any other cycle.
- Arbitration within a grant slot:
  - Only dmem_req -> data wins.
  - Only imem_req -> fetch wins.
  - Both requesting, starve_cnt == STARVE_LIMIT -> fetch wins.
  - Both requesting, otherwise -> data wins.
- Grant cycle:
  - The winner's gnt = 1 and mem_req = 1; mem_addr/we/be/wdata carry the winner's fields, all combinational in the same cycle.
  - arb_owner is registered to the winner; state -> BUSY.
- Slot with no request: mem_req = 0 and mem_* data outputs = 0. BUSY with mem_rvalid -> IDLE.
- Response routing (combinational):
  - When state == BUSY and mem_rvalid == 1, rvalid and rdata go to arb_owner's port; the other port's rvalid = 0 and rdata = 0.
- Stray response: mem_rvalid while IDLE is ignored; no rvalid output.
- starve_cnt update, in any grant slot:
  - Data wins while imem_req == 1 -> starve_cnt increments, saturating at STARVE_LIMIT.
  - Fetch wins -> starve_cnt clears.
  - Otherwise starve_cnt holds.
- Requesters hold req and their fields stable until gnt; the arbiter does not latch unaccepted requests.
- Reset while BUSY:
  - The outstanding transaction is abandoned and no rvalid is produced.
  - A late mem_rvalid after reset is treated as a stray response.
- Throughput: with a 1-cycle memory, one grant per cycle sustained (the grant slot comes from mem_rvalid).

Optional Feature:
- Macro: SODOR_MEM_ARB_PERF_EN.
- With the macro defined, three 32-bit outputs are added:
  - perf_igrant: count of fetch grants.
  - perf_dgrant: count of data grants.
  - perf_conflict: count of grant slots with both requests active.
- All three counters reset to 0, wrap modulo 2^32 and increment in the same cycle as the event.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sodor_mem_arb_pkg holds:
  - The state enum (IDLE, BUSY).
  - Size-code constants MEM_BE_BYTE = 3'b001, MEM_BE_HALF = 3'b010, MEM_BE_WORD = 3'b011.
  - The owner constants OWNER_FETCH = 0 and OWNER_DATA = 1.
- One sub-module, sodor_mem_arb_starve, holds the saturating starvation counter; it outputs a force_fetch flag.

Test Plan:
1. Fetch only: imem_req = 1, addr 0x100, memory rvalid 1 cycle later with rdata 0xDEADBEEF -> imem_gnt in cycle 0, mem_we = 0, mem_be = 3'b011, imem_rvalid in cycle 1 with 0xDEADBEEF, dmem_rvalid = 0.
2. Simultaneous requests: imem 0x200, dmem store 0x80 with wdata 0x12345678 and be 001 -> dmem wins, mem_we = 1, mem_wdata = 0x12345678; next slot fetch is granted; starve_cnt goes 1 then 0.
3. Starvation: imem_req held while dmem_req is high for 6 slots, STARVE_LIMIT = 4 -> data wins 4 slots, fetch wins the 5th, data wins the 6th.
4. Back-to-back: 1-cycle memory, dmem loads to 0x0, 0x4, 0x8 -> three consecutive dmem_gnt cycles, three consecutive dmem_rvalid cycles, mem_req never drops.
5. Reset mid-transaction: dmem granted, reset asserted before rvalid, mem_rvalid arrives after reset -> no dmem_rvalid, state IDLE, starve_cnt 0.
6. With SODOR_MEM_ARB_PERF_EN: scenario 3 -> perf_dgrant = 5, perf_igrant = 1, perf_conflict = 5.
